// File: rtl/axi_lite_arbiter_ctrl.sv
// Round-robin arbiter and transaction sequencer sharing one AXI4-Lite slave port
// between NUM_M masters, with a stalled-slave watchdog.
//
// state | meaning
// IDLE  | no grant; arbitrate among requesting masters
// RADDR | read granted, waiting for AR handshake
// RDATA | waiting for R handshake
// WADDR | write granted, waiting for AW (W may complete first)
// WDATA | AW done, waiting for W handshake
// WRESP | AW and W done, waiting for B handshake
module axi_lite_arbiter_ctrl #(
    parameter int NUM_M   = 2,
    parameter int TIMEOUT = 256
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETN,
    input  logic [NUM_M-1:0]                       m_arvalid,
    input  logic [NUM_M-1:0]                       m_awvalid,
    input  logic                                   s_arvalid,
    input  logic                                   s_arready,
    input  logic                                   s_rvalid,
    input  logic                                   s_rready,
    input  logic                                   s_awvalid,
    input  logic                                   s_awready,
    input  logic                                   s_wvalid,
    input  logic                                   s_wready,
    input  logic                                   s_bvalid,
    input  logic                                   s_bready,
    output logic [NUM_M-1:0]                       grant,
    output logic [(NUM_M > 1 ? $clog2(NUM_M) : 1)-1:0] grant_idx,
    output logic                                   grant_write,
    output logic [2:0]                             state,
    output logic                                   timeout_o
);

    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WADDR = 3'd3,
        WDATA = 3'd4,
        WRESP = 3'd5
    } state_type;

    state_type              state_q, state_d;
    logic [NUM_M-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   write_q, write_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   w_done_q, w_done_d;

    logic                   ar_hs, r_hs, aw_hs, w_hs, b_hs, any_hs;
    logic [NUM_M-1:0]       req;
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;

    assign ar_hs  = s_arvalid & s_arready;
    assign r_hs   = s_rvalid  & s_rready;
    assign aw_hs  = s_awvalid & s_awready;
    assign w_hs   = s_wvalid  & s_wready;
    assign b_hs   = s_bvalid  & s_bready;
    assign any_hs = ar_hs | r_hs | aw_hs | w_hs | b_hs;
    assign req    = m_arvalid | m_awvalid;

    // First requester at or above the pointer, wrapping from NUM_M-1 back to 0.
    always_comb begin
        int c;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_M; k++) begin
            c = int'(rr_ptr_q) + k;
            if (c >= NUM_M) c = c - NUM_M;
            if (!win_found && req[c]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(c);
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            rr_ptr_q <= '0;
            w_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            rr_ptr_q <= rr_ptr_d;
            w_done_q <= w_done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        write_d  = write_q;
        rr_ptr_d = rr_ptr_q;
        w_done_d = w_done_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d  = NUM_M'(1) << win_idx;
                    idx_d    = win_idx;
                    write_d  = m_awvalid[win_idx];
                    state_d  = m_awvalid[win_idx] ? WADDR : RADDR;
                    rr_ptr_d = (win_idx == IDX_W'(NUM_M - 1)) ? '0 : win_idx + 1'b1;
                end
            end
            RADDR: if (ar_hs) state_d = RDATA;
            RDATA: begin
                if (r_hs) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    idx_d    = '0;
                    write_d  = 1'b0;
                    w_done_d = 1'b0;
                end
            end
            WADDR: begin
                // WDATA itself records that AW has completed, so only W needs a flag.
                if (aw_hs) begin
                    state_d = (w_done_q || w_hs) ? WRESP : WDATA;
                end else if (w_hs) begin
                    w_done_d = 1'b1;
                end
            end
            WDATA: if (w_hs) state_d = WRESP;
            WRESP: begin
                if (b_hs) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    idx_d    = '0;
                    write_d  = 1'b0;
                    w_done_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                idx_d    = '0;
                write_d  = 1'b0;
                w_done_d = 1'b0;
            end
        endcase
    end

    generate
        if (TIMEOUT > 0) begin : g_wdog
            logic [WD_W-1:0] wd_cnt_q;
            logic            wd_pulse_q;
            logic            stall;

            assign stall = (state_q != IDLE) && !any_hs;

            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    wd_cnt_q   <= '0;
                    wd_pulse_q <= 1'b0;
                end else if (!stall) begin
                    wd_cnt_q   <= '0;
                    wd_pulse_q <= 1'b0;
                end else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
                    wd_cnt_q   <= '0;
                    wd_pulse_q <= 1'b1;
                end else begin
                    wd_cnt_q   <= wd_cnt_q + 1'b1;
                    wd_pulse_q <= 1'b0;
                end
            end

            assign timeout_o = wd_pulse_q;
        end else begin : g_no_wdog
            assign timeout_o = 1'b0;
        end
    endgenerate

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_write = write_q;
    assign state       = state_q;

endmodule

// File: tb/tb_axi_lite_arbiter_ctrl.sv
// Directed bench for axi_lite_arbiter_ctrl: two masters, watchdog TIMEOUT=8.
module tb_axi_lite_arbiter_ctrl;

    localparam int NUM_M = 2;
    localparam logic [2:0] S_IDLE = 3'd0, S_RADDR = 3'd1, S_RDATA = 3'd2,
                           S_WADDR = 3'd3, S_WDATA = 3'd4, S_WRESP = 3'd5;

    logic             ACLK = 1'b0;
    logic             ARESETN;
    logic [NUM_M-1:0] m_arvalid, m_awvalid;
    logic             s_arvalid, s_arready, s_rvalid, s_rready;
    logic             s_awvalid, s_awready, s_wvalid, s_wready;
    logic             s_bvalid, s_bready;
    logic [NUM_M-1:0] grant;
    logic [0:0]       grant_idx;
    logic             grant_write;
    logic [2:0]       state;
    logic             timeout_o;

    int n_chk  = 0;
    int n_pass = 0;

    axi_lite_arbiter_ctrl #(.NUM_M(NUM_M), .TIMEOUT(8)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .m_arvalid(m_arvalid), .m_awvalid(m_awvalid),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant(grant), .grant_idx(grant_idx), .grant_write(grant_write),
        .state(state), .timeout_o(timeout_o)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_slave();
        s_arvalid = 0; s_arready = 0; s_rvalid = 0; s_rready = 0;
        s_awvalid = 0; s_awready = 0; s_wvalid = 0; s_wready = 0;
        s_bvalid = 0; s_bready = 0;
    endtask

    task automatic b_finish(input string tag);
        s_bvalid = 1; s_bready = 1;
        tick();
        chk({tag, "_idle"}, 32'(state), 32'(S_IDLE));
        chk({tag, "_gnt0"}, 32'(grant), 32'h0);
        clear_slave();
    endtask

    logic [NUM_M-1:0] rr_exp [9] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};

    initial begin
        ARESETN = 0; m_arvalid = '0; m_awvalid = '0;
        clear_slave();
        repeat (3) tick();
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_tmo", 32'(timeout_o), 32'h0);
        ARESETN = 1;
        repeat (2) tick();
        chk("idle_norq", 32'(state), 32'(S_IDLE));

        // single read from master 0, AR ready after 2 cycles, R after 3
        m_arvalid = 2'b01;
        tick();
        chk("rd_grant", 32'(grant), 32'h1);
        chk("rd_state", 32'(state), 32'(S_RADDR));
        chk("rd_wr", 32'(grant_write), 32'h0);
        m_arvalid = '0; s_arvalid = 1;
        tick(); tick();
        chk("rd_wait_ar", 32'(state), 32'(S_RADDR));
        s_arready = 1;
        tick();
        chk("rd_rdata", 32'(state), 32'(S_RDATA));
        clear_slave(); s_rvalid = 1;
        tick(); tick();
        chk("rd_wait_r", 32'(state), 32'(S_RDATA));
        chk("rd_hold", 32'(grant), 32'h1);
        s_rready = 1;
        tick();
        chk("rd_done", 32'(state), 32'(S_IDLE));
        chk("rd_gnt0", 32'(grant), 32'h0);
        clear_slave();

        // pointer now 1: master 1 wins over master 0; write beats read
        m_arvalid = 2'b11; m_awvalid = 2'b10;
        tick();
        chk("pri_grant", 32'(grant), 32'h2);
        chk("pri_idx", 32'(grant_idx), 32'h1);
        chk("pri_wr", 32'(grant_write), 32'h1);
        chk("pri_state", 32'(state), 32'(S_WADDR));
        m_arvalid = '0; m_awvalid = '0;
        s_awvalid = 1; s_awready = 1;
        tick();
        chk("awfirst_wdata", 32'(state), 32'(S_WDATA));
        clear_slave(); s_wvalid = 1; s_wready = 1;
        tick();
        chk("awfirst_wresp", 32'(state), 32'(S_WRESP));
        clear_slave();
        b_finish("awfirst");

        // pointer now 0: W two cycles before AW skips WDATA
        m_awvalid = 2'b01;
        tick();
        chk("wfirst_grant", 32'(grant), 32'h1);
        m_awvalid = '0; s_wvalid = 1; s_wready = 1;
        tick();
        chk("wfirst_waddr", 32'(state), 32'(S_WADDR));
        clear_slave();
        tick();
        s_awvalid = 1; s_awready = 1;
        tick();
        chk("wfirst_wresp", 32'(state), 32'(S_WRESP));
        clear_slave();
        b_finish("wfirst");

        // pointer now 1: AW and W in the same cycle
        m_awvalid = 2'b10;
        tick();
        chk("same_grant", 32'(grant), 32'h2);
        m_awvalid = '0;
        s_awvalid = 1; s_awready = 1; s_wvalid = 1; s_wready = 1;
        tick();
        chk("same_wresp", 32'(state), 32'(S_WRESP));
        clear_slave();
        b_finish("same");

        // pointer now 0: both masters write continuously, slave always ready
        m_awvalid = 2'b11;
        s_awvalid = 1; s_awready = 1; s_wvalid = 1; s_wready = 1;
        s_bvalid = 1; s_bready = 1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("rr_%0d", i), 32'(grant), 32'(rr_exp[i]));
        end
        m_awvalid = '0;
        clear_slave();
        tick();
        chk("rr_end", 32'(state), 32'(S_IDLE));

        // pointer now 1: reset asserted mid-WDATA takes effect without a clock
        m_awvalid = 2'b10;
        tick();
        m_awvalid = '0; s_awvalid = 1; s_awready = 1;
        tick();
        chk("mid_wdata", 32'(state), 32'(S_WDATA));
        clear_slave();
        ARESETN = 0;
        #1;
        chk("arst_state", 32'(state), 32'(S_IDLE));
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_tmo", 32'(timeout_o), 32'h0);
        repeat (3) tick();
        ARESETN = 1;
        repeat (2) tick();
        chk("arst_idle", 32'(state), 32'(S_IDLE));

        // watchdog: AR never accepted
        m_arvalid = 2'b01;
        tick();
        chk("wd_grant", 32'(grant), 32'h1);
        m_arvalid = '0; s_arvalid = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("wd_tmo_%0d", i), 32'(timeout_o), 32'((i % 8) == 0));
        end
        chk("wd_state", 32'(state), 32'(S_RADDR));
        chk("wd_hold", 32'(grant), 32'h1);
        clear_slave();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
